// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Two-entry ready/valid skid stage with a bubble-gated control
//                field, a data field, flush and an occupancy report.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int CTRL_W   = 12,
    parameter int DATA_W   = 143,
    parameter int CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_accept;
    logic              w_pop;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_main_from_skid;

    // Handshake outputs decode only the state register, never out_ready.
    assign in_ready  = (r_state != ST_FULL) & ~rst;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUSY;
                    w_load_main = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_accept && !w_pop) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ST_BUSY;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLR_DATA != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main_ctrl <= w_main_from_skid ? r_skid_ctrl : in_ctrl;
                r_main_data <= w_main_from_skid ? r_skid_data : in_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Scoreboard bench for pipe_stage_skid (CLR_DATA 0 and 1 builds).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int CW = 12;
    localparam int DW = 143;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    occ0, occ1;

    ent_t sb[$];
    int   exp_occ = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   mon_en  = 1'b0;
    bit   m_acc, m_pop;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_d();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Reference model: a FIFO of at most two entries, emptied by rst/flush.
    always @(posedge clk) begin
        if (rst || flush) begin
            exp_occ = 0;
            sb.delete();
        end else begin
            m_pop = (exp_occ > 0) && out_ready;
            m_acc = in_valid && (exp_occ < 2);
            if (m_acc) sb.push_back(ent_t'{c: in_ctrl, d: in_data});
            exp_occ = exp_occ - int'(m_pop) + int'(m_acc);
        end
    end

    task automatic mon_dut(input string tag, input logic ir, input logic ov,
                           input logic [CW-1:0] oc, input logic [1:0] occ);
        chk({tag, "_in_ready"}, 160'(ir), 160'(!rst && exp_occ < 2));
        chk({tag, "_occupancy"}, 160'(occ), 160'(exp_occ));
        chk({tag, "_out_valid"}, 160'(ov), 160'(exp_occ > 0));
        if (!ov) chk({tag, "_bubble_ctrl"}, 160'(oc), 160'(0));
    endtask

    // Monitor: compares the presented head with the scoreboard front, pops on transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_dut("d0", in_ready0, out_valid0, out_ctrl0, occ0);
            mon_dut("d1", in_ready1, out_valid1, out_ctrl1, occ1);
            if (out_valid0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 160'(1), 160'(0));
                end else begin
                    chk("d0_head_ctrl", 160'(out_ctrl0), 160'(sb[0].c));
                    chk("d0_head_data", 160'(out_data0), 160'(sb[0].d));
                    chk("d1_head_ctrl", 160'(out_ctrl1), 160'(sb[0].c));
                    chk("d1_head_data", 160'(out_data1), 160'(sb[0].d));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Flip out_ready mid-cycle: in_ready must not follow it.
    task automatic probe_indep();
        logic r0;
        r0        = in_ready0;
        out_ready = ~out_ready;
        #1;
        chk("in_ready_vs_out_ready", 160'(in_ready0), 160'(r0));
        out_ready = ~out_ready;
        #1;
    endtask

    logic [DW-1:0] a_d, e1_d, e2_d, e3_d;
    int            rdy_pct;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        step();
        mon_en = 1'b1;
        step();
        chk("rst_out_data0", 160'(out_data0), 160'(0));
        chk("rst_out_data1", 160'(out_data1), 160'(0));
        chk("rst_in_ready", 160'(in_ready0), 160'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 160'(in_ready0), 160'(1));
        step();

        // Single entry, one-cycle latency
        a_d = rnd_d();
        offer(12'h123, a_d);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", 160'(out_valid0), 160'(1));
        chk("t1_ctrl", 160'(out_ctrl0), 160'(12'h123));
        chk("t1_data", 160'(out_data0), 160'(a_d));
        chk("t1_occ", 160'(occ0), 160'(1));
        step();
        chk("t1_empty", 160'(out_valid0), 160'(0));

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            offer(CW'($urandom), rnd_d());
            step();
            chk("t2_in_ready", 160'(in_ready0), 160'(1));
            chk("t2_occ", 160'(occ0), 160'(1));
        end
        in_valid = 1'b0;
        step(); step();

        // Stall absorbs exactly one extra entry
        out_ready = 1'b0;
        e1_d = rnd_d(); e2_d = rnd_d(); e3_d = rnd_d();
        offer(12'h0E1, e1_d); step();
        offer(12'h0E2, e2_d); step();
        offer(12'h0E3, e3_d); step();
        chk("t3_occ_full", 160'(occ0), 160'(2));
        chk("t3_in_ready", 160'(in_ready0), 160'(0));
        chk("t3_head_held", 160'(out_data0), 160'(e1_d));
        out_ready = 1'b1;
        step();
        chk("t3_second", 160'(out_data0), 160'(e2_d));
        step();
        in_valid = 1'b0;
        chk("t3_third", 160'(out_data0), 160'(e3_d));
        step();
        chk("t3_drained", 160'(out_valid0), 160'(0));

        // Flush with both entries held and a new offer
        out_ready = 1'b0;
        e1_d = rnd_d(); e2_d = rnd_d();
        offer(12'h0A1, e1_d); step();
        offer(12'h0A2, e2_d); step();
        chk("t4_occ_full", 160'(occ0), 160'(2));
        flush = 1'b1;
        in_valid = 1'b1; in_ctrl = 12'h0A4; in_data = rnd_d();
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_valid", 160'(out_valid0), 160'(0));
        chk("t4_occ", 160'(occ0), 160'(0));
        chk("t4_ctrl", 160'(out_ctrl0), 160'(0));
        chk("t4_keep_data", 160'(out_data0), 160'(e1_d));
        chk("t4_clr_data", 160'(out_data1), 160'(0));
        out_ready = 1'b1;
        step(); step();
        chk("t4_no_e4", 160'(out_valid0), 160'(0));

        // Reset while full
        out_ready = 1'b0;
        offer(CW'($urandom), rnd_d()); step();
        offer(CW'($urandom), rnd_d()); step();
        rst = 1'b1; out_ready = 1'b1;
        offer(CW'($urandom), rnd_d());
        #1;
        chk("t5_in_ready_rst", 160'(in_ready0), 160'(0));
        step();
        out_ready = 1'b0;
        chk("t5_valid", 160'(out_valid0), 160'(0));
        chk("t5_occ", 160'(occ0), 160'(0));
        chk("t5_data0", 160'(out_data0), 160'(0));
        chk("t5_data1", 160'(out_data1), 160'(0));
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_in_ready_after", 160'(in_ready0), 160'(1));
        step();

        // Randomized traffic; idle inputs carry garbage
        rdy_pct = 70;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) rdy_pct = $urandom_range(10, 95);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = rnd_d();
            out_ready = ($urandom_range(1, 100) <= rdy_pct);
            flush     = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) probe_indep();
            step();
        end

        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("final_occ", 160'(occ0), 160'(0));
        chk("final_sb_empty", 160'(sb.size()), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
